// File: rtl/pipe_control_unit.sv
// pipe_control_unit: ID opcode decode carried through EX/MEM/WB stage registers,
// with RAW-hazard stall, branch/jump flush and saturating stall/flush counters.
module pipe_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int REG_W    = 6,
  parameter int ALUOP_W  = 3,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                ex_zero,
  input  logic                ex_neg,
  output logic                stall,
  output logic                flush,
  output logic                illegal,
  output logic [1:0]          ex_aluSrc,
  output logic [ALUOP_W-1:0]  ex_aluOp,
  output logic                ex_savePc,
  output logic                mem_memRead,
  output logic                mem_memWrite,
  output logic                wb_regWrite,
  output logic                wb_memToReg,
  output logic [REG_W-1:0]    wb_rd,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);
  typedef struct packed {
    logic               reg_write;
    logic [1:0]         alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               save_pc;
    logic               mem_write;
    logic               mem_read;
    logic               mem_to_reg;
    logic               branch;
    logic               br_neg;
    logic               jump;
  } ctrl_t;
  typedef struct packed {
    logic             valid;
    ctrl_t            c;
    logic [REG_W-1:0] rd;
  } ex_t;
  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] rd;
  } mem_t;
  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] rd;
  } wb_t;
  ctrl_t      dec;
  logic       known, check, redirect, hz_ex, hz_mem, hazard;
  logic [3:0] op4;
  ex_t        ex_q, ex_d;
  mem_t       mem_q;
  wb_t        wb_q;
  assign op4 = id_opcode[3:0];
  always_comb begin
    dec   = '0;
    known = (id_opcode >> 4) == '0;
    case (op4)
      4'b0000: ;
      4'b1111: begin dec.reg_write = 1'b1; dec.alu_src = 2'b01; dec.alu_op = ALUOP_W'(3'b100); dec.save_pc = 1'b1; end
      4'b1110: begin dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; end
      4'b0011: dec.mem_write = 1'b1;
      4'b0100: begin dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(3'b100); end
      4'b0101: begin dec.reg_write = 1'b1; dec.alu_src = 2'b01; dec.alu_op = ALUOP_W'(3'b100); end
      4'b0110: begin dec.reg_write = 1'b1; dec.alu_src = 2'b10; dec.alu_op = ALUOP_W'(3'b010); end
      4'b0111: begin dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(3'b001); end
      4'b1000: dec.jump = 1'b1;
      4'b1001: dec.branch = 1'b1;
      4'b1011: begin dec.branch = 1'b1; dec.br_neg = 1'b1; end
      default: known = 1'b0;
    endcase
    if (!known) dec = '0;
  end
  assign redirect = ex_q.valid & (ex_q.c.jump | (ex_q.c.branch & (ex_q.c.br_neg ? ex_neg : ex_zero)));
  assign check    = id_valid & known & (op4 != 4'b0000) & (op4 != 4'b1000);
  assign hz_ex    = ex_q.valid & ex_q.c.reg_write & ((id_rs == ex_q.rd) | (id_rt == ex_q.rd));
  assign hz_mem   = mem_q.valid & mem_q.reg_write & ((id_rs == mem_q.rd) | (id_rt == mem_q.rd));
  assign hazard   = check & ((FWD_EN != 0) ? (hz_ex & ex_q.c.mem_read) : (hz_ex | hz_mem));
  assign stall    = hazard & ~redirect;
  assign flush    = redirect;
  // illegal is purely combinational, so it is gated to read 0 while reset is held
  assign illegal  = rst_n & id_valid & ~known;
  // invalid or squashed slots enter EX as all-zero bubbles so no stray control reaches later stages
  assign ex_d = (stall | flush | ~id_valid | ~known) ? '0 : ex_t'{valid: 1'b1, c: dec, rd: id_rd};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_t'{valid: ex_q.valid, reg_write: ex_q.c.reg_write, mem_read: ex_q.c.mem_read,
                          mem_write: ex_q.c.mem_write, mem_to_reg: ex_q.c.mem_to_reg, rd: ex_q.rd};
      wb_q      <= wb_t'{reg_write: mem_q.reg_write, mem_to_reg: mem_q.mem_to_reg, rd: mem_q.rd};
      stall_cnt <= stall_cnt + CNT_W'(stall & ~&stall_cnt);
      flush_cnt <= flush_cnt + CNT_W'(flush & ~&flush_cnt);
    end
  end
  assign ex_aluSrc    = ex_q.c.alu_src;
  assign ex_aluOp     = ex_q.c.alu_op;
  assign ex_savePc    = ex_q.c.save_pc;
  assign mem_memRead  = mem_q.mem_read;
  assign mem_memWrite = mem_q.mem_write;
  assign wb_regWrite  = wb_q.reg_write;
  assign wb_memToReg  = wb_q.mem_to_reg;
  assign wb_rd        = wb_q.rd;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: table-driven, hand-sequenced and random checks of two builds
// (forwarding/16-bit counters and no-forwarding/4-bit counters) against a stage-list model.
module tb_pipe_control_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       id_valid = 1'b0, ex_zero = 1'b0, ex_neg = 1'b0;
  logic [3:0] id_opcode = '0;
  logic [5:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic st_a, fl_a, il_a, spc_a, mr_a, mw_a, rw_a, m2r_a;
  logic st_b, fl_b, il_b, spc_b, mr_b, mw_b, rw_b, m2r_b;
  logic [1:0]  src_a, src_b;
  logic [2:0]  aop_a, aop_b;
  logic [5:0]  wrd_a, wrd_b;
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;
  typedef struct packed {
    logic st, fl, il;
    logic [1:0] src;
    logic [2:0] aop;
    logic spc, mr, mw, rw, m2r;
    logic [5:0] wrd;
    logic [15:0] sc, fc;
  } obs_t;
  obs_t oa, ob;
  assign oa = {st_a, fl_a, il_a, src_a, aop_a, spc_a, mr_a, mw_a, rw_a, m2r_a, wrd_a, sc_a, fc_a};
  assign ob = {st_b, fl_b, il_b, src_b, aop_b, spc_b, mr_b, mw_b, rw_b, m2r_b, wrd_b, 12'd0, sc_b, 12'd0, fc_b};
  pipe_control_unit #(.FWD_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_zero(ex_zero), .ex_neg(ex_neg), .stall(st_a), .flush(fl_a), .illegal(il_a),
    .ex_aluSrc(src_a), .ex_aluOp(aop_a), .ex_savePc(spc_a), .mem_memRead(mr_a), .mem_memWrite(mw_a),
    .wb_regWrite(rw_a), .wb_memToReg(m2r_a), .wb_rd(wrd_a), .stall_cnt(sc_a), .flush_cnt(fc_a));
  pipe_control_unit #(.FWD_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_zero(ex_zero), .ex_neg(ex_neg), .stall(st_b), .flush(fl_b), .illegal(il_b),
    .ex_aluSrc(src_b), .ex_aluOp(aop_b), .ex_savePc(spc_b), .mem_memRead(mr_b), .mem_memWrite(mw_b),
    .wb_regWrite(rw_b), .wb_memToReg(m2r_b), .wb_rd(wrd_b), .stall_cnt(sc_b), .flush_cnt(fc_b));
  typedef struct packed {
    bit v, rw;
    bit [1:0] src;
    bit [2:0] aop;
    bit spc, mw, mr, m2r, br, bn, j;
    bit [5:0] rd;
  } ins_t;
  ins_t m [2][3];
  int   scm [2], fcm [2];
  int   n_vec = 0, n_err = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic ins_t decode(input logic [3:0] op, output bit leg);
    ins_t d = '0;
    leg = 1'b1;
    case (op)
      4'h0: ;
      4'hf: begin d.rw = 1'b1; d.src = 2'd1; d.aop = 3'd4; d.spc = 1'b1; end
      4'he: begin d.rw = 1'b1; d.mr = 1'b1; d.m2r = 1'b1; end
      4'h3: d.mw = 1'b1;
      4'h4: begin d.rw = 1'b1; d.aop = 3'd4; end
      4'h5: begin d.rw = 1'b1; d.src = 2'd1; d.aop = 3'd4; end
      4'h6: begin d.rw = 1'b1; d.src = 2'd2; d.aop = 3'd2; end
      4'h7: begin d.rw = 1'b1; d.aop = 3'd1; end
      4'h8: d.j = 1'b1;
      4'h9: d.br = 1'b1;
      4'hb: begin d.br = 1'b1; d.bn = 1'b1; end
      default: leg = 1'b0;
    endcase
    return d;
  endfunction
  function automatic bit uses(input ins_t s);
    return s.v && s.rw && (id_rs == s.rd || id_rt == s.rd);
  endfunction
  function automatic obs_t model_obs(input int k);
    ins_t e, q, w, d;
    bit leg, red, chk, haz;
    obs_t o;
    e = m[k][0]; q = m[k][1]; w = m[k][2];
    d = decode(id_opcode, leg);
    red = e.v && (e.j || (e.br && (e.bn ? ex_neg : ex_zero)));
    chk = id_valid && leg && d != '0 && !d.j;
    haz = chk && (k == 0 ? (uses(e) && e.mr) : (uses(e) || uses(q)));
    o = '0;
    o.st = haz && !red; o.fl = red; o.il = id_valid && !leg;
    o.src = e.src; o.aop = e.aop; o.spc = e.spc;
    o.mr = q.mr; o.mw = q.mw;
    o.rw = w.rw; o.m2r = w.m2r; o.wrd = w.rd;
    o.sc = 16'(scm[k]); o.fc = 16'(fcm[k]);
    return o;
  endfunction
  task automatic model_clear;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) m[k][s] = '0;
      scm[k] = 0; fcm[k] = 0;
    end
  endtask
  task automatic cyc(input int v, input int op, input int rs, input int rt, input int rd, input int z, input int n);
    @(negedge clk);
    id_valid = v[0]; id_opcode = 4'(op); id_rs = 6'(rs); id_rt = 6'(rt); id_rd = 6'(rd);
    ex_zero = z[0]; ex_neg = n[0];
    #1;
    for (int k = 0; k < 2; k++) begin
      obs_t x;
      ins_t d;
      bit leg;
      int lim;
      x = model_obs(k);
      d = decode(id_opcode, leg);
      lim = k ? 15 : 65535;
      check(k ? "model_b" : "model_a", k ? 64'(ob) : 64'(oa), 64'(x));
      m[k][2] = m[k][1]; m[k][1] = m[k][0];
      if (x.st || x.fl || !id_valid || !leg) m[k][0] = '0;
      else begin m[k][0] = d; m[k][0].v = 1'b1; m[k][0].rd = id_rd; end
      if (x.st && scm[k] < lim) scm[k]++;
      if (x.fl && fcm[k] < lim) fcm[k]++;
    end
  endtask
  task automatic do_reset;
    @(negedge clk);
    id_valid = 1'b1; id_opcode = 4'ha; rst_n = 1'b0;
    #1;
    check("reset_a", 64'(oa), 64'd0);
    check("reset_b", 64'(ob), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; id_valid = 1'b0; id_opcode = '0;
    model_clear();
  endtask
  typedef struct {
    int v, op, rs, rt, rd, z, n, st, fl, il, aop, wrw, wrd, sc, fc;
  } vec_t;
  vec_t tbl [23];
  initial begin
    tbl = '{
      '{1, 4'h4, 1, 2, 5, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0},
      '{0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 4, 0, 0, 0, 0},
      '{0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0},
      '{0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 5, 0, 0},
      '{1, 4'he, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0},
      '{1, 4'h7, 3, 1, 4, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0},
      '{1, 4'h7, 3, 1, 4, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0},
      '{0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 3, 1, 0},
      '{1, 4'h9, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0},
      '{0, 0,    0, 0, 0, 1, 0,  0, 1, 0, 0, 1, 4, 1, 0},
      '{0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1},
      '{1, 4'h9, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1},
      '{0, 0,    0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1, 1},
      '{1, 4'hb, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1},
      '{0, 0,    0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 1, 1},
      '{1, 4'he, 0, 0, 7, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2},
      '{1, 4'h8, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2},
      '{1, 4'h7, 7, 0, 2, 0, 0,  0, 1, 0, 0, 0, 0, 1, 2},
      '{0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 7, 1, 3},
      '{1, 4'ha, 0, 0, 9, 0, 0,  0, 0, 1, 0, 0, 0, 1, 3},
      '{0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 3},
      '{0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 3},
      '{0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 3}
    };
    model_clear();
    do_reset();
    foreach (tbl[i]) begin
      vec_t t;
      t = tbl[i];
      cyc(t.v, t.op, t.rs, t.rt, t.rd, t.z, t.n);
      check($sformatf("row%0d_stall", i), 64'(st_a), 64'(t.st));
      check($sformatf("row%0d_flush", i), 64'(fl_a), 64'(t.fl));
      check($sformatf("row%0d_illegal", i), 64'(il_a), 64'(t.il));
      check($sformatf("row%0d_ex_aluOp", i), 64'(aop_a), 64'(t.aop));
      check($sformatf("row%0d_wb_regWrite", i), 64'(rw_a), 64'(t.wrw));
      check($sformatf("row%0d_wb_rd", i), 64'(wrd_a), 64'(t.wrd));
      check($sformatf("row%0d_stall_cnt", i), 64'(sc_a), 64'(t.sc));
      check($sformatf("row%0d_flush_cnt", i), 64'(fc_a), 64'(t.fc));
    end
    // no-forwarding build: ALU RAW stalls two cycles; repeated pairs drive the 4-bit counter into saturation
    do_reset();
    for (int p = 0; p < 10; p++) begin
      cyc(1, 4'h4, 0, 0, 3, 0, 0);
      cyc(1, 4'h7, 3, 0, 4, 0, 0);
      if (p == 0) check("nofwd_stall1", 64'(st_b), 64'd1);
      cyc(1, 4'h7, 3, 0, 4, 0, 0);
      if (p == 0) check("nofwd_stall2", 64'(st_b), 64'd1);
      cyc(1, 4'h7, 3, 0, 4, 0, 0);
      if (p == 0) check("nofwd_stall3", 64'(st_b), 64'd0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("sat_stall_cnt_b", 64'(sc_b), 64'd15);
    check("fwd_stall_cnt_a", 64'(sc_a), 64'd0);
    // jump in EX while a RAW against MEM is pending: redirect wins, then reset mid-flush
    do_reset();
    cyc(1, 4'he, 0, 0, 7, 0, 0);
    cyc(1, 4'h8, 0, 0, 0, 0, 0);
    cyc(1, 4'h7, 7, 0, 2, 0, 0);
    check("redirect_stall_b", 64'(st_b), 64'd0);
    check("redirect_flush_b", 64'(fl_b), 64'd1);
    check("redirect_flush_a", 64'(fl_a), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_a", 64'(oa), 64'd0);
    check("async_reset_b", 64'(ob), 64'd0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
